// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Purpose:
//   Arbitrates one single-port framebuffer VRAM between the display fetch path
//   and two pixel writers. Display fetches have absolute priority. Writes are
//   shared round-robin between the two requesters. The screen (640x480) is
//   downscaled onto a FB_W x FB_H framebuffer by dropping SCALE_SHIFT LSBs of
//   each coordinate.
//
// Ports:
//   clk                  system clock; all state updates on posedge
//   reset                asynchronous, active-low reset
//   pix_tick             one-clk strobe per pixel period
//   video_on             visible-area flag, sampled with pix_tick
//   x, y                 current screen coordinates, sampled with pix_tick
//   wr_req0/1            write requests, held with address/data until granted
//   wr_addr0/1           framebuffer write addresses
//   wr_data0/1           write colour data
//   wr_gnt0/1            one-clk grant pulse, coincident with the VRAM write
//   mem_addr/we/wdata    registered single-port VRAM command
//   mem_rdata            VRAM read data, valid one clk after a read command
//   rgb                  registered pixel colour towards the DAC
//   stall_cnt            saturating count of clocks a request waited
//
// Build option:
//   VRAM_ARB_STALL_CNT_EN  when defined, stall_cnt is a live counter;
//                          otherwise stall_cnt is tied to zero.
// ---------------------------------------------------------------------------
`default_nettype none

module vram_arbiter #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int COLOR_W     = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_tick,
    input  logic               video_on,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               wr_req0,
    input  logic               wr_req1,
    input  logic [14:0]        wr_addr0,
    input  logic [14:0]        wr_addr1,
    input  logic [COLOR_W-1:0] wr_data0,
    input  logic [COLOR_W-1:0] wr_data1,
    output logic               wr_gnt0,
    output logic               wr_gnt1,
    output logic [14:0]        mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [COLOR_W-1:0] rgb,
    output logic [15:0]        stall_cnt
);

    // Number of addressable framebuffer words; writes at or beyond this are dropped.
    localparam logic [15:0] FB_SIZE = 16'(FB_W * FB_H);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISP_RD  = 2'd1,
        DISP_CAP = 2'd2,
        WR       = 2'd3
    } state_t;

    state_t               state_r;
    logic                 fetch_pend_r;
    logic [14:0]          fetch_addr_r;
    logic                 rr_r;          // requester preferred when both ask
    logic                 wr_gnt0_r;
    logic                 wr_gnt1_r;
    logic [14:0]          mem_addr_r;
    logic                 mem_we_r;
    logic [COLOR_W-1:0]   mem_wdata_r;
    logic [COLOR_W-1:0]   rgb_r;

    logic                 tick_vis_s;
    logic                 tick_blank_s;
    logic                 any_req_s;
    logic                 pick1_s;
    logic [14:0]          sel_addr_s;
    logic [COLOR_W-1:0]   sel_data_s;
    logic                 addr_ok_s;
    logic [14:0]          fetch_addr_s;
    logic                 disp_go_s;
    logic                 wr_go_s;

    assign tick_vis_s   = pix_tick & video_on;
    assign tick_blank_s = pix_tick & ~video_on;
    assign any_req_s    = wr_req0 | wr_req1;

    // Downscaled framebuffer address of the current screen pixel. Only visible
    // coordinates are used, so the result always fits in 15 bits.
    assign fetch_addr_s = 15'(y >> SCALE_SHIFT) * 15'(FB_W) + 15'(x >> SCALE_SHIFT);

    // Round-robin selection: a lone requester wins, contention goes to rr_r.
    always_comb begin
        pick1_s = 1'b0;
        if (wr_req0 && wr_req1) begin
            pick1_s = rr_r;
        end else if (wr_req1) begin
            pick1_s = 1'b1;
        end else begin
            pick1_s = 1'b0;
        end
    end

    assign sel_addr_s = pick1_s ? wr_addr1 : wr_addr0;
    assign sel_data_s = pick1_s ? wr_data1 : wr_data0;
    assign addr_ok_s  = ({1'b0, sel_addr_s} < FB_SIZE);

    // A tick seen in IDLE is served immediately, so it blocks a write in the
    // same clock exactly like an already pending fetch does.
    assign disp_go_s = (state_r == IDLE) && (tick_vis_s || fetch_pend_r);
    assign wr_go_s   = (state_r == IDLE) && !disp_go_s && any_req_s;

    // Main arbiter FSM with all VRAM command, grant and pixel outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            fetch_pend_r <= 1'b0;
            fetch_addr_r <= 15'd0;
            rr_r         <= 1'b0;
            wr_gnt0_r    <= 1'b0;
            wr_gnt1_r    <= 1'b0;
            mem_addr_r   <= 15'd0;
            mem_we_r     <= 1'b0;
            mem_wdata_r  <= {COLOR_W{1'b0}};
            rgb_r        <= {COLOR_W{1'b0}};
        end else begin
            // Grants and write enable are single-cycle pulses.
            wr_gnt0_r <= 1'b0;
            wr_gnt1_r <= 1'b0;
            mem_we_r  <= 1'b0;

            // The most recent visible tick always owns the pending address.
            if (tick_vis_s) begin
                fetch_addr_r <= fetch_addr_s;
            end else begin
                fetch_addr_r <= fetch_addr_r;
            end

            case (state_r)
                IDLE: begin
                    if (disp_go_s) begin
                        state_r      <= DISP_RD;
                        mem_addr_r   <= tick_vis_s ? fetch_addr_s : fetch_addr_r;
                        fetch_pend_r <= 1'b0;
                    end else if (wr_go_s) begin
                        state_r     <= WR;
                        mem_addr_r  <= sel_addr_s;
                        mem_wdata_r <= sel_data_s;
                        mem_we_r    <= addr_ok_s;
                        wr_gnt0_r   <= ~pick1_s;
                        wr_gnt1_r   <= pick1_s;
                        rr_r        <= ~pick1_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DISP_RD: begin
                    state_r <= DISP_CAP;
                    if (tick_vis_s) begin
                        fetch_pend_r <= 1'b1;
                    end else begin
                        fetch_pend_r <= fetch_pend_r;
                    end
                end
                DISP_CAP: begin
                    state_r <= IDLE;
                    rgb_r   <= mem_rdata;
                    if (tick_vis_s) begin
                        fetch_pend_r <= 1'b1;
                    end else begin
                        fetch_pend_r <= fetch_pend_r;
                    end
                end
                WR: begin
                    state_r <= IDLE;
                    if (tick_vis_s) begin
                        fetch_pend_r <= 1'b1;
                    end else begin
                        fetch_pend_r <= fetch_pend_r;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    fetch_pend_r <= 1'b0;
                end
            endcase

            // Blanking is the newest information about the pixel, so it
            // overrides a capture landing on the same edge.
            if (tick_blank_s) begin
                rgb_r <= {COLOR_W{1'b0}};
            end
        end
    end

`ifdef VRAM_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Count clocks in which a request is present but no grant is issued; saturate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 16'h0000;
        end else if (any_req_s && !wr_go_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

    assign wr_gnt0   = wr_gnt0_r;
    assign wr_gnt1   = wr_gnt1_r;
    assign mem_addr  = mem_addr_r;
    assign mem_we    = mem_we_r;
    assign mem_wdata = mem_wdata_r;
    assign rgb       = rgb_r;

endmodule

`default_nettype wire
